imem_port_arbiter: RTL and testbench

Owns the single port of the synchronous instruction memory and shares it between the CPU fetch path and a program loader stream. After reset it holds the CPU stalled while the loader fills the memory, then grants fetch by default. It admits loader writes during execution through a bounded-starvation rule. It sits between the PC/fetch stage, the loader interface and the instruction RAM.

---
 rtl/imem_pkg.sv | 14 +
 rtl/starve_counter.sv | 37 +++
 rtl/imem_port_arbiter.sv | 118 +++++++++++
 tb/tb_imem_port_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter, its RAM and the fetch stage.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 4;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of fetch wins over a pending loader write; clear has priority over increment.
module starve_counter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max = (count_q == CNT_MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-RAM port between CPU fetch and the boot/program loader.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DATA_W     = IMEM_DATA_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              boot_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  logic   fetch_valid_q, fetch_valid_d;
  logic   oob_q, oob_d;
  logic   boot_done_q, boot_done_d;
  logic   cnt_inc, cnt_clr, at_max;
  logic   in_range;
  logic   unused_pc_lsb;

  assign in_range      = (fetch_pc[31:ADDR_W+2] == '0);
  assign unused_pc_lsb = ^fetch_pc[1:0];

  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (at_max)
  );

  // Port ownership: loader during boot, fetch by default afterwards unless the loader is starved.
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = 1'b0;
    oob_d         = 1'b0;
    boot_done_d   = boot_done_q;
    stall         = 1'b1;
    ld_ready      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cnt_inc       = 1'b0;
    cnt_clr       = 1'b1;
    if (rst_n) begin
      if (state_q == ST_BOOT) begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
          if (ld_last) begin
            state_d     = ST_RUN;
            boot_done_d = 1'b1;
          end
        end
      end else begin
        stall    = at_max && ld_valid;
        ld_ready = !fetch_req || at_max;
        if (ld_valid && ld_ready) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end else if (fetch_req) begin
          fetch_valid_d = 1'b1;
          oob_d         = !in_range;
          mem_en        = in_range;
          mem_addr      = fetch_pc[ADDR_W+1:2];
          if (ld_valid) begin
            cnt_inc = 1'b1;
            cnt_clr = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      fetch_valid_q <= 1'b0;
      oob_q         <= 1'b0;
      boot_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      oob_q         <= oob_d;
      boot_done_q   <= boot_done_d;
    end
  end

  // RAM output register supplies the data; out-of-range and idle cycles present a NOP.
  assign fetch_instr = (fetch_valid_q && !oob_q) ? mem_rdata : DATA_W'(NOP);
  assign fetch_valid = fetch_valid_q;
  assign boot_done   = boot_done_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed plus randomized bench for imem_port_arbiter with a behavioural RAM and reference model.
module tb_imem_port_arbiter;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;
  localparam int          SMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;
  logic          stall;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          boot_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [31:0] ram     [16] = '{default: '0};
  logic [31:0] ref_mem [16] = '{default: '0};

  int   checks = 0;
  int   errors = 0;
  bit   m_run = 0, m_bd = 0, m_fv = 0;
  int   m_starve = 0;
  logic [31:0] m_fi = '0;
  logic obs_ldr, obs_stall, obs_en;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .stall(stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .boot_done(boot_done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port instruction RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    bit e_stall, e_ldr, e_en, e_we, forced, lgrant, fgrant, inr, rst_now;
    int idx, n_starve;
    bit n_run, n_bd, n_fv;
    logic [31:0] n_fi;
    #1;
    inr     = (fetch_pc < 32'd64);
    idx     = int'((fetch_pc >> 2) & 32'hF);
    forced  = ld_valid && (m_starve == SMAX);
    lgrant  = 1'b0;
    fgrant  = 1'b0;
    rst_now = !rst_n;
    if (rst_now) begin
      e_stall = 1; e_ldr = 0; e_en = 0; e_we = 0;
    end else if (!m_run) begin
      lgrant = ld_valid;
      e_stall = 1; e_ldr = 1; e_en = ld_valid; e_we = 1;
    end else begin
      lgrant  = ld_valid && (!fetch_req || forced);
      fgrant  = fetch_req && !forced;
      e_stall = forced; e_ldr = lgrant; e_en = lgrant || (fgrant && inr); e_we = lgrant;
    end
    obs_ldr = ld_ready; obs_stall = stall; obs_en = mem_en;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (ld_valid || rst_now) chk("ld_ready", 32'(ld_ready), 32'(e_ldr));
    if (e_en) chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en && e_we) begin
      chk("mem_addr_wr", 32'(mem_addr), 32'(ld_addr));
      chk("mem_wdata", mem_wdata, ld_data);
    end
    if (e_en && !e_we) chk("mem_addr_rd", 32'(mem_addr), 32'(idx));

    n_fv = fgrant;
    n_fi = inr ? ref_mem[idx] : 32'h0;
    n_run = m_run; n_bd = m_bd; n_starve = m_starve;
    if (rst_now) begin
      n_run = 0; n_bd = 0; n_starve = 0; n_fv = 0;
    end else begin
      if (lgrant) ref_mem[ld_addr] = ld_data;
      if (!m_run && lgrant && ld_last) begin n_run = 1; n_bd = 1; end
      if (!m_run || !ld_valid || lgrant) n_starve = 0;
      else if (fetch_req) n_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    end

    @(posedge clk);
    #1;
    m_run = n_run; m_bd = n_bd; m_starve = n_starve; m_fv = n_fv; m_fi = n_fi;
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    if (m_fv) chk("fetch_instr", fetch_instr, m_fi);
    if (rst_now) chk("fetch_instr_rst", fetch_instr, 32'h0);
    chk("boot_done", 32'(boot_done), 32'(m_bd));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] boot_img [3];
    logic [31:0] seq_exp  [3];
    int grant_cycle;
    boot_img = '{32'h8C02000E, 32'h00623020, 32'h00C33821};

    rst_n = 0; fetch_req = 0; fetch_pc = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
    @(negedge clk);
    tick(); tick();
    chk("rst_boot_done", 32'(boot_done), 32'h0);

    // Boot load of three words
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_addr = AW'(i); ld_data = boot_img[i]; ld_last = (i == 2);
      fetch_req = 1; fetch_pc = 32'h4;
      tick();
      chk("boot_stall", 32'(obs_stall), 32'h1);
    end
    chk("boot_done_rise", 32'(boot_done), 32'h1);
    ld_valid = 0; ld_last = 0;

    // Fetch latency and back-to-back fetches
    fetch_req = 1; fetch_pc = 32'h4;
    tick();
    chk("fetch4_valid", 32'(fetch_valid), 32'h1);
    chk("fetch4_instr", fetch_instr, 32'h00623020);
    seq_exp = boot_img;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'(i * 4);
      tick();
      chk("b2b_instr", fetch_instr, seq_exp[i]);
    end

    // Starvation: loader forced through on the ninth contended cycle
    fetch_pc = 32'h0; ld_valid = 1; ld_addr = 4'd3; ld_data = 32'h00221820;
    grant_cycle = 0;
    for (int c = 1; c <= 20 && grant_cycle == 0; c++) begin
      tick();
      if (obs_ldr) begin
        grant_cycle = c;
        chk("starve_stall", 32'(obs_stall), 32'h1);
      end
    end
    chk("starve_cycle", 32'(grant_cycle), 32'd9);
    ld_valid = 0; fetch_pc = 32'hC;
    tick();
    chk("raw_fetch12", fetch_instr, 32'h00221820);

    // Idle-fetch write
    fetch_req = 0; ld_valid = 1; ld_addr = 4'd5; ld_data = $urandom;
    tick();
    chk("idle_ld_ready", 32'(obs_ldr), 32'h1);
    ld_valid = 0;

    // Out-of-range fetch
    fetch_req = 1; fetch_pc = 32'h40;
    tick();
    chk("oob_mem_en", 32'(obs_en), 32'h0);
    chk("oob_valid", 32'(fetch_valid), 32'h1);
    chk("oob_instr", fetch_instr, 32'h0);

    // Reset during a boot beat, then during a pending fetch
    rst_n = 0; ld_valid = 1; ld_addr = 4'd1; ld_data = 32'hDEADBEEF; ld_last = 1;
    tick();
    chk("mid_rst_bd", 32'(boot_done), 32'h0);
    rst_n = 1;
    tick();
    ld_valid = 0; ld_last = 0; fetch_pc = 32'h8;
    tick();
    rst_n = 0;
    tick();
    chk("mid_rst_fv", 32'(fetch_valid), 32'h0);
    rst_n = 1;
    tick();
    chk("rst_back_boot", 32'(obs_stall), 32'h1);

    // Randomized traffic with occasional resets and reboots
    for (int n = 0; n < 500; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      fetch_req = ($urandom_range(0, 9) < 7);
      fetch_pc  = ($urandom_range(0, 7) == 0) ? $urandom
                                              : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      ld_valid  = ($urandom_range(0, 9) < 7);
      ld_addr   = AW'($urandom_range(0, 15));
      ld_data   = $urandom;
      ld_last   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
